// File: rtl/bcd_binario_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bcd_binario_seq_pkg                                             |
// | Brief    : Shared state encoding and digit-correction constants.           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package bcd_binario_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] C_DIGIT_THRESHOLD = 4'd8;
    localparam logic [3:0] C_DIGIT_ADJUST    = 4'd3;
    localparam logic [3:0] C_DIGIT_MAX       = 4'd9;

endpackage : bcd_binario_seq_pkg
`default_nettype wire

// File: rtl/bcd_binario_seq_digit_sub3.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bcd_digit_sub3                                                  |
// | Brief    : One BCD digit correction step: subtract 3 when digit >= 8.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module bcd_digit_sub3
    import bcd_binario_seq_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    // The >= 8 guard keeps the subtraction inside the nibble, so no borrow leaves it.
    assign digit_o = (digit_i >= C_DIGIT_THRESHOLD) ? (digit_i - C_DIGIT_ADJUST) : digit_i;

endmodule : bcd_digit_sub3
`default_nettype wire

// File: rtl/bcd_binario_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bcd_binario_seq                                                 |
// | Brief    : Multi-cycle BCD-to-binary converter, one reverse dabble per clk.|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module bcd_binario_seq
    import bcd_binario_seq_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   DATA_BCD,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [4*DIGITS-1:0]   D_Binary
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(W + 1);

    state_t          r_state_q;
    logic [2*W-1:0]  r_work_q;
    logic [CW-1:0]   r_cnt_q;
    logic            r_busy_q;
    logic            r_done_q;
    logic            r_error_q;
    logic [W-1:0]    r_bin_q;

    logic [2*W-1:0]  w_shifted;
    logic [W-1:0]    w_bcd_adj;
    logic [2*W-1:0]  w_work_d;
    logic [DIGITS-1:0] w_nib_bad;
    logic            w_invalid;

    assign w_shifted = {1'b0, r_work_q[2*W-1:1]};

    generate
        for (genvar d = 0; d < DIGITS; d++) begin : g_digit
            bcd_digit_sub3 u_sub3 (
                .digit_i (w_shifted[W + 4*d +: 4]),
                .digit_o (w_bcd_adj[4*d +: 4])
            );
            assign w_nib_bad[d] = (DATA_BCD[4*d +: 4] > C_DIGIT_MAX);
        end
    endgenerate

    assign w_work_d  = {w_bcd_adj, w_shifted[W-1:0]};
    assign w_invalid = |w_nib_bad;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state_q <= IDLE;
            r_work_q  <= '0;
            r_cnt_q   <= '0;
            r_busy_q  <= 1'b0;
            r_done_q  <= 1'b0;
            r_error_q <= 1'b0;
            r_bin_q   <= '0;
        end else begin
            case (r_state_q)
                IDLE: begin
                    r_done_q <= 1'b0;
                    if (start) begin
                        if (w_invalid) begin
                            r_state_q <= DONE;
                            r_done_q  <= 1'b1;
                            r_error_q <= 1'b1;
                            r_bin_q   <= '0;
                        end else begin
                            r_state_q <= SHIFT;
                            r_busy_q  <= 1'b1;
                            r_work_q  <= {DATA_BCD, {W{1'b0}}};
                            r_cnt_q   <= '0;
                        end
                    end
                end
                SHIFT: begin
                    r_work_q <= w_work_d;
                    r_cnt_q  <= r_cnt_q + 1'b1;
                    // Last shift: the binary half is complete after this edge's shift.
                    if (r_cnt_q == CW'(W - 1)) begin
                        r_state_q <= DONE;
                        r_busy_q  <= 1'b0;
                        r_done_q  <= 1'b1;
                        r_error_q <= 1'b0;
                        r_bin_q   <= w_shifted[W-1:0];
                    end
                end
                DONE: begin
                    r_done_q  <= 1'b0;
                    r_state_q <= IDLE;
                end
                default: begin
                    r_state_q <= IDLE;
                    r_busy_q  <= 1'b0;
                    r_done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy_q;
    assign done     = r_done_q;
    assign error    = r_error_q;
    assign D_Binary = r_bin_q;

endmodule : bcd_binario_seq
`default_nettype wire
